// File: rtl/mem_wb_stage.sv
// mem_wb_stage: data-memory access and MEM/WB register of the rv32i core.
// Optional MEM_ALIGN_CHECK_EN suppresses and flags misaligned word accesses.
module mem_wb_stage #(
    parameter int DPW  = 32,
    parameter int ADW  = 5,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            validM,
    input  logic            regwriteM,
    input  logic            resultsrcM,
    input  logic            memwriteM,
    input  logic [DPW-1:0]  aluresultM,
    input  logic [DPW-1:0]  Rd2M,
    input  logic [4:0]      RdM,
    output logic            validW,
    output logic            regwriteW,
    output logic [4:0]      RdW,
    output logic [DPW-1:0]  resultW,
    output logic            misalignW,
    output logic [CNTW-1:0] ldcnt,
    output logic [CNTW-1:0] stcnt
);

    localparam int DEPTH = 1 << ADW;

    logic [DPW-1:0]  mem [DEPTH];
    logic [ADW-1:0]  idx;
    logic [DPW-1:0]  rdata;
    logic            mis;
    logic            is_load;
    logic            st;
    logic            ld;
    logic            unused_addr;

    // Word index; upper bits wrap, byte-offset bits only feed the checker.
    assign idx         = aluresultM[ADW+1:2];
    assign unused_addr = ^{aluresultM[DPW-1:ADW+2], aluresultM[1:0]};

`ifdef MEM_ALIGN_CHECK_EN
    assign mis = validM & (memwriteM | resultsrcM)
               & (aluresultM[1:0] != 2'b00);
`else
    assign mis = 1'b0;
`endif

    // A store wins when both memwriteM and resultsrcM are set.
    assign is_load = resultsrcM & ~memwriteM;
    assign st      = validM & memwriteM & ~mis;
    assign ld      = validM & is_load & ~mis;
    assign rdata   = mem[idx];

    // Data memory: cleared on reset, otherwise written by committed stores.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (st) begin
            mem[idx] <= Rd2M;
        end
    end

    // MEM/WB register, advances every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            validW    <= 1'b0;
            regwriteW <= 1'b0;
            RdW       <= '0;
            resultW   <= '0;
            misalignW <= 1'b0;
        end else begin
            validW    <= validM;
            regwriteW <= validM & regwriteM & (RdM != 5'd0) & ~mis;
            RdW       <= RdM;
            resultW   <= is_load ? rdata : aluresultM;
            misalignW <= validM & mis;
        end
    end

    // Saturating committed load/store counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            ldcnt <= '0;
            stcnt <= '0;
        end else begin
            if (ld && (ldcnt != {CNTW{1'b1}})) begin
                ldcnt <= ldcnt + CNTW'(1);
            end
            if (st && (stcnt != {CNTW{1'b1}})) begin
                stcnt <= stcnt + CNTW'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: table vectors plus model-driven traffic for mem_wb_stage.
// Expected W bundles are queued at drive time and compared one cycle later.
module tb_mem_wb_stage;

    typedef struct {
        logic        v, rw, rs, mw;
        logic [31:0] a, d;
        logic [4:0]  rd;
    } op_t;

    typedef struct {
        logic        v, rw;
        logic [4:0]  rd;
        logic [31:0] res;
        logic        mis;
        logic [3:0]  ld, st;
    } exp_t;

    typedef struct {
        op_t  op;
        exp_t e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        validM, regwriteM, resultsrcM, memwriteM;
    logic [31:0] aluresultM, Rd2M;
    logic [4:0]  RdM;
    logic        validW, regwriteW, misalignW;
    logic [4:0]  RdW;
    logic [31:0] resultW;
    logic [3:0]  ldcnt, stcnt;

    int checks = 0;
    int errors = 0;

    exp_t        q[$];
    logic [31:0] mmem [32];
    int          mld, mst;
    vec_t        tbl [13];

    mem_wb_stage #(.DPW(32), .ADW(5), .CNTW(4)) dut (
        .clk(clk), .rst(rst),
        .validM(validM), .regwriteM(regwriteM),
        .resultsrcM(resultsrcM), .memwriteM(memwriteM),
        .aluresultM(aluresultM), .Rd2M(Rd2M), .RdM(RdM),
        .validW(validW), .regwriteW(regwriteW), .RdW(RdW),
        .resultW(resultW), .misalignW(misalignW),
        .ldcnt(ldcnt), .stcnt(stcnt)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(
        logic v, rw, rs, mw, logic [31:0] a, d, logic [4:0] rd,
        logic ev, erw, logic [4:0] erd, logic [31:0] eres,
        logic emis, logic [3:0] eld, est);
        vec_t t;
        t.op = '{v: v, rw: rw, rs: rs, mw: mw, a: a, d: d, rd: rd};
        t.e  = '{v: ev, rw: erw, rd: erd, res: eres,
                 mis: emis, ld: eld, st: est};
        return t;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) mmem[i] = '0;
        mld = 0;
        mst = 0;
    endfunction

    // Reference behaviour of one M slot; updates memory and counters.
    function automatic exp_t model(op_t o);
        exp_t        e;
        logic [4:0]  i;
        logic        m;
        logic        lde, ste;
        i = o.a[6:2];
`ifdef MEM_ALIGN_CHECK_EN
        m = o.v & (o.mw | o.rs) & (o.a[1:0] != 2'b00);
`else
        m = 1'b0;
`endif
        ste   = o.v & o.mw & ~m;
        lde   = o.v & o.rs & ~o.mw & ~m;
        e.v   = o.v;
        e.rw  = o.v & o.rw & (o.rd != 5'd0) & ~m;
        e.rd  = o.rd;
        e.res = (o.rs & ~o.mw) ? mmem[i] : o.a;
        e.mis = m;
        if (ste) mmem[i] = o.d;
        if (lde && mld < 15) mld++;
        if (ste && mst < 15) mst++;
        e.ld = mld[3:0];
        e.st = mst[3:0];
        return e;
    endfunction

    task automatic drive(op_t o);
        validM     = o.v;
        regwriteM  = o.rw;
        resultsrcM = o.rs;
        memwriteM  = o.mw;
        aluresultM = o.a;
        Rd2M       = o.d;
        RdM        = o.rd;
    endtask

    task automatic step(string nm, op_t o, exp_t e);
        exp_t g;
        drive(o);
        q.push_back(e);
        @(posedge clk);
        #1;
        g = q.pop_front();
        chk({nm, ".validW"}, {31'd0, validW}, {31'd0, g.v});
        chk({nm, ".regwriteW"}, {31'd0, regwriteW}, {31'd0, g.rw});
        chk({nm, ".misalignW"}, {31'd0, misalignW}, {31'd0, g.mis});
        chk({nm, ".ldcnt"}, {28'd0, ldcnt}, {28'd0, g.ld});
        chk({nm, ".stcnt"}, {28'd0, stcnt}, {28'd0, g.st});
        if (g.v) begin
            chk({nm, ".RdW"}, {27'd0, RdW}, {27'd0, g.rd});
            chk({nm, ".resultW"}, resultW, g.res);
        end
    endtask

    task automatic chk_reset_out(string nm);
        chk({nm, ".validW"}, {31'd0, validW}, 32'd0);
        chk({nm, ".regwriteW"}, {31'd0, regwriteW}, 32'd0);
        chk({nm, ".misalignW"}, {31'd0, misalignW}, 32'd0);
        chk({nm, ".RdW"}, {27'd0, RdW}, 32'd0);
        chk({nm, ".resultW"}, resultW, 32'd0);
        chk({nm, ".ldcnt"}, {28'd0, ldcnt}, 32'd0);
        chk({nm, ".stcnt"}, {28'd0, stcnt}, 32'd0);
    endtask

    initial begin
        op_t  o;
        exp_t e;

        tbl[0]  = mk(1,0,0,1, 32'h10, 32'hDEADBEEF, 0,
                     1,0,0, 32'h10, 0, 0, 1);
        tbl[1]  = mk(1,1,1,0, 32'h10, 32'h0, 5,
                     1,1,5, 32'hDEADBEEF, 0, 1, 1);
        tbl[2]  = mk(1,0,0,1, 32'h84, 32'h12345678, 0,
                     1,0,0, 32'h84, 0, 1, 2);
        tbl[3]  = mk(1,1,1,0, 32'h04, 32'h0, 6,
                     1,1,6, 32'h12345678, 0, 2, 2);
        tbl[4]  = mk(1,1,0,0, 32'h07, 32'h0, 0,
                     1,0,0, 32'h07, 0, 2, 2);
        tbl[5]  = mk(0,1,0,1, 32'h10, 32'h55, 3,
                     0,0,3, 32'h10, 0, 2, 2);
        tbl[6]  = mk(1,1,1,0, 32'h10, 32'h0, 7,
                     1,1,7, 32'hDEADBEEF, 0, 3, 2);
        tbl[7]  = mk(1,1,0,0, 32'hCAFE, 32'h0, 9,
                     1,1,9, 32'hCAFE, 0, 3, 2);
        tbl[8]  = mk(1,1,1,1, 32'h08, 32'h11, 4,
                     1,1,4, 32'h08, 0, 3, 3);
        tbl[9]  = mk(1,1,1,0, 32'h08, 32'h0, 4,
                     1,1,4, 32'h11, 0, 4, 3);
`ifdef MEM_ALIGN_CHECK_EN
        tbl[10] = mk(1,0,0,1, 32'h22, 32'hAAAAAAAA, 0,
                     1,0,0, 32'h22, 1, 4, 3);
        tbl[11] = mk(1,1,1,0, 32'h20, 32'h0, 2,
                     1,1,2, 32'h0, 0, 5, 3);
        tbl[12] = mk(1,1,1,0, 32'h13, 32'h0, 3,
                     1,0,3, 32'hDEADBEEF, 1, 5, 3);
`else
        tbl[10] = mk(1,0,0,1, 32'h22, 32'hAAAAAAAA, 0,
                     1,0,0, 32'h22, 0, 4, 4);
        tbl[11] = mk(1,1,1,0, 32'h20, 32'h0, 2,
                     1,1,2, 32'hAAAAAAAA, 0, 5, 4);
        tbl[12] = mk(1,1,1,0, 32'h13, 32'h0, 3,
                     1,1,3, 32'hDEADBEEF, 0, 6, 4);
`endif

        o = '{v: 0, rw: 0, rs: 0, mw: 0, a: 0, d: 0, rd: 0};
        drive(o);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_out("init");
        rst = 1'b0;
        model_reset();

        for (int i = 0; i < 13; i++) begin
            e = model(tbl[i].op);
            step($sformatf("vec%0d", i), tbl[i].op, tbl[i].e);
        end

        for (int i = 0; i < 40; i++) begin
            o.v  = ($urandom_range(0, 7) != 0);
            o.rw = $urandom_range(0, 1);
            o.rs = $urandom_range(0, 1);
            o.mw = ($urandom_range(0, 2) == 0);
            o.a  = $urandom() & 32'hFFFF_FFFC;
            o.d  = $urandom();
            o.rd = 5'($urandom_range(0, 31));
            e = model(o);
            step($sformatf("rnd%0d", i), o, e);
        end

        o = '{v: 1, rw: 0, rs: 0, mw: 1, a: 32'h10,
              d: 32'h5A5A5A5A, rd: 0};
        drive(o);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_reset_out("rst1");
        @(posedge clk);
        #1;
        chk_reset_out("rst2");
        rst = 1'b0;
        model_reset();

        for (int i = 0; i < 4; i++) begin
            o = '{v: 1, rw: 1, rs: 1, mw: 0, a: 32'(i * 36),
                  d: 0, rd: 5'(i + 1)};
            e = model(o);
            step($sformatf("postrst%0d", i), o, e);
            chk($sformatf("postrst%0d.zero", i), resultW, 32'd0);
        end

        model_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 17; i++) begin
            o = '{v: 1, rw: 0, rs: 0, mw: 1, a: 32'(i * 4),
                  d: 32'(i + 100), rd: 0};
            e = model(o);
            step($sformatf("sat%0d", i), o, e);
        end
        chk("stcnt_sat", {28'd0, stcnt}, 32'd15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
